demux18_dispatch: RTL and testbench
===================================

DEMUX18_DISPATCH -- requirements
Module: demux18_dispatch

Interface
REQ-001 Parameter: W, 8, data width in bits.
REQ-002 Parameter: TIMEOUT, 16, max SEND cycles waiting for out_ready (range 1..255); 0 disables timeout.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  upstream item present.
REQ-006 Port: in_ready  output  1  block can accept an item this cycle.
REQ-007 Port: in_data  input  W  item payload.
REQ-008 Port: in_dest  input  3  destination channel (addressed mode).
REQ-009 Port: mode  input  1  0 = addressed, 1 = round-robin.
REQ-010 Port: en_mask  input  8  per-channel enable; bit k enables channel k.
REQ-011 Port: out_valid  output  8  one-hot valid toward channel sel; all-zero when idle.
REQ-012 Port: out_ready  input  8  per-channel downstream ready.
REQ-013 Port: out_data  output  W  latched payload, common to all channels.
REQ-014 Port: sel  output  3  select of the 1:8 demux datapath.
REQ-015 Port: drop_cnt  output  8  count of discarded items, saturating.
REQ-016 Port: busy  output  1  high in SEND.

Function
REQ-017 FSM states SHALL be IDLE and SEND; busy = (state==SEND).
REQ-018 IDLE: in_ready SHALL be 1; out_valid SHALL be 0.
REQ-019 SEND: in_ready SHALL be 0; out_valid SHALL equal one-hot(sel).
REQ-020 Acceptance = in_valid & in_ready at a rising edge; mode, en_mask, in_dest, in_data SHALL be sampled only at acceptance.
REQ-021 Addressed mode: target = in_dest; if en_mask[in_dest]==0 the item SHALL be dropped (drop_cnt+1, stay IDLE).
REQ-022 Round-robin mode: target = first k with en_mask[k]==1 searching ptr, ptr+1, ... mod 8; if en_mask==0 the item SHALL be dropped.
REQ-023 On non-dropped acceptance: out_data <= in_data, sel <= target, state <= SEND, timeout counter <= 0; out_valid asserts the cycle after acceptance (latency 1).
REQ-024 SEND: transfer when out_ready[sel]==1; next edge state <= IDLE; if item accepted in round-robin mode, ptr <= (sel+1) mod 8.
REQ-025 Addressed-mode deliveries SHALL NOT modify ptr.
REQ-026 SEND, TIMEOUT!=0, no transfer: counter increments each cycle; when counter reaches TIMEOUT-1 without transfer, item SHALL be dropped (drop_cnt+1, state <= IDLE, ptr unchanged).
REQ-027 Transfer and timeout in the same cycle: transfer SHALL win, no drop counted.
REQ-028 en_mask or mode changes during SEND SHALL NOT affect the in-flight item.
REQ-029 drop_cnt SHALL saturate at 255 and never wrap.
REQ-030 sel and out_data SHALL hold their last value in IDLE.
REQ-031 Max throughput: one item per 2 cycles (no accept in the transfer cycle).

Reset
REQ-032 rst high at an edge SHALL force: state IDLE, out_valid 0, sel 0, out_data 0, ptr 0, drop_cnt 0, timeout counter 0, in_ready 1 after release.
REQ-033 rst during SEND SHALL abort the item with no drop count.

Verification
REQ-034 Addressed: mode=0, en_mask=FF, in_dest=5, in_data=A5, out_ready=FF -> next cycle out_valid=20, sel=5, out_data=A5; IDLE one cycle later.
REQ-035 Disabled dest: mode=0, en_mask=DF, in_dest=5 -> no out_valid, drop_cnt 0->1, in_ready stays 1.
REQ-036 Round-robin: mode=1, en_mask=29 (ch 0,3,5), 4 items, out_ready=FF -> sel sequence 0,3,5,0.
REQ-037 Timeout: TIMEOUT=4, out_ready=00, one item to ch 2 -> out_valid=04 for exactly 4 cycles, then 0, drop_cnt=1.
REQ-038 Saturation/reset: 260 drops (en_mask=00) -> drop_cnt=255; assert rst mid-SEND -> next cycle out_valid=0, drop_cnt=0, sel=0.

Source files
------------

// File: rtl/demux18_dispatch_if.sv
// Bus bundle for the 1:8 dispatch demux: upstream item handshake, per-channel
// downstream valid/ready, shared payload/select and status.
interface demux18_dispatch_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_dest;
  logic         mode;
  logic [7:0]   en_mask;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   sel;
  logic [7:0]   drop_cnt;
  logic         busy;

  modport slave (
    input  in_valid, in_data, in_dest, mode, en_mask, out_ready,
    output in_ready, out_valid, out_data, sel, drop_cnt, busy
  );

  modport master (
    output in_valid, in_data, in_dest, mode, en_mask, out_ready,
    input  in_ready, out_valid, out_data, sel, drop_cnt, busy
  );
endinterface

// File: rtl/demux18_dispatch.sv
// Single-item 1:8 dispatcher: routes an accepted item to an addressed or
// round-robin channel, with optional send timeout and saturating drop count.
module demux18_dispatch #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  demux18_dispatch_if.slave    bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [W-1:0]     data_q, data_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       drop_q, drop_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             rr_item_q, rr_item_d;
  logic [7:0]       out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             rr_found;
  logic [2:0]       rr_idx;
  logic [2:0]       tgt;
  logic             tgt_ok;
  logic             drop_ev;

  // First enabled channel at or after the round-robin pointer
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!rr_found && bus.en_mask[ptr_q + 3'(i)]) begin
        rr_found = 1'b1;
        rr_idx   = ptr_q + 3'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    drop_d    = drop_q;
    tcnt_d    = tcnt_q;
    rr_item_d = rr_item_q;
    drop_ev   = 1'b0;

    if (bus.mode) begin
      tgt    = rr_idx;
      tgt_ok = rr_found;
    end else begin
      tgt    = bus.in_dest;
      tgt_ok = bus.en_mask[bus.in_dest];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (tgt_ok) begin
            state_d   = S_SEND;
            sel_d     = tgt;
            data_d    = bus.in_data;
            tcnt_d    = '0;
            rr_item_d = bus.mode;
          end else begin
            drop_ev = 1'b1;
          end
        end
      end
      S_SEND: begin
        // A transfer always beats a coincident timeout
        if (bus.out_ready[sel_q]) begin
          state_d = S_IDLE;
          if (rr_item_q) ptr_d = sel_q + 3'd1;
        end else if (TIMEOUT != 0) begin
          if (tcnt_q == TO_LAST) begin
            state_d = S_IDLE;
            drop_ev = 1'b1;
          end else begin
            tcnt_d = tcnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (drop_ev && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_SEND);
    out_valid_d = busy_d ? (8'd1 << sel_d) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      data_q      <= '0;
      ptr_q       <= '0;
      drop_q      <= '0;
      tcnt_q      <= '0;
      rr_item_q   <= 1'b0;
      out_valid_q <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      drop_q      <= drop_d;
      tcnt_q      <= tcnt_d;
      rr_item_q   <= rr_item_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_demux18_dispatch.sv
// Bench for demux18_dispatch: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_demux18_dispatch;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux18_dispatch_if #(.W(W)) bus ();
  demux18_dispatch #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  int unsigned m_ptr, m_drops, m_sel, m_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.mode      = 1'b0;
    bus.en_mask   = 8'h00;
    bus.out_ready = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0; m_drops = 0; m_sel = 0; m_data = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL reset_valid: got %h want 00", bus.out_valid); else n_pass++;
    n_checks++; if (bus.sel !== 3'd0) $display("FAIL reset_sel: got %0d want 0", bus.sel); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.out_data); else n_pass++;
    n_checks++; if (bus.drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_addressed();
    do_reset();
    bus.mode = 1'b0; bus.en_mask = 8'hFF; bus.in_dest = 3'd5; bus.in_data = 8'hA5;
    bus.out_ready = 8'hFF; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 8'h20) $display("FAIL addr_valid: got %h want 20", bus.out_valid); else n_pass++;
    n_checks++; if (bus.sel !== 3'd5) $display("FAIL addr_sel: got %0d want 5", bus.sel); else n_pass++;
    n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL addr_data: got %h want a5", bus.out_data); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) $display("FAIL addr_send_flags: got rdy=%b busy=%b want 0/1", bus.in_ready, bus.busy); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 8'h00 || bus.in_ready !== 1'b1) $display("FAIL addr_idle: got valid=%h rdy=%b want 00/1", bus.out_valid, bus.in_ready); else n_pass++;
    n_checks++; if (bus.sel !== 3'd5 || bus.out_data !== 8'hA5) $display("FAIL addr_hold: got sel=%0d data=%h want 5/a5", bus.sel, bus.out_data); else n_pass++;
  endtask

  task automatic test_disabled_dest();
    do_reset();
    bus.mode = 1'b0; bus.en_mask = 8'hDF; bus.in_dest = 3'd5; bus.in_data = 8'h3C;
    bus.out_ready = 8'hFF; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL dis_valid: got %h want 00", bus.out_valid); else n_pass++;
    n_checks++; if (bus.drop_cnt !== 8'd1) $display("FAIL dis_drop: got %0d want 1", bus.drop_cnt); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL dis_in_ready: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel [4];
    exp_sel = '{3'd0, 3'd3, 3'd5, 3'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.mode = 1'b1; bus.en_mask = 8'h29; bus.in_data = 8'(i + 16);
      bus.out_ready = 8'hFF; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.sel !== exp_sel[i]) $display("FAIL rr_sel%0d: got %0d want %0d", i, bus.sel, exp_sel[i]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_timeout();
    int unsigned cnt;
    do_reset();
    bus.mode = 1'b0; bus.en_mask = 8'hFF; bus.in_dest = 3'd2; bus.in_data = 8'h77;
    bus.out_ready = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (bus.out_valid == 8'h04 && cnt < 20) begin
      cnt++;
      tick();
    end
    n_checks++; if (cnt != TO) $display("FAIL to_len: got %0d cycles want %0d", cnt, TO); else n_pass++;
    n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL to_valid: got %h want 00", bus.out_valid); else n_pass++;
    n_checks++; if (bus.drop_cnt !== 8'd1) $display("FAIL to_drop: got %0d want 1", bus.drop_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.mode = 1'b0; bus.en_mask = 8'hFF; bus.out_ready = 8'hFF; bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_dest = 3'($urandom); bus.in_data = 8'($urandom);
      tick();
      n_checks++; if (bus.busy !== ((i % 2) == 0)) $display("FAIL b2b_busy%0d: got %b want %b", i, bus.busy, ((i % 2) == 0)); else n_pass++;
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int unsigned md, mask, dest, data, t, d;
    bit ok, done;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      md   = $urandom_range(0, 1);
      mask = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      dest = $urandom_range(0, 7);
      data = $urandom_range(0, 255);
      ok = 1'b0; t = 0;
      if (md == 0) begin
        ok = mask[dest]; t = dest;
      end else begin
        for (int k = 0; k < 8; k++)
          if (!ok && mask[(m_ptr + k) % 8]) begin ok = 1'b1; t = (m_ptr + k) % 8; end
      end
      bus.mode = md[0]; bus.en_mask = 8'(mask); bus.in_dest = 3'(dest);
      bus.in_data = 8'(data); bus.out_ready = 8'($urandom); bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      if (!ok) begin
        if (m_drops < 255) m_drops++;
        n_checks++; if (bus.out_valid !== 8'h00 || bus.in_ready !== 1'b1) $display("FAIL rnd_drop_idle%0d: got valid=%h rdy=%b want 00/1", n, bus.out_valid, bus.in_ready); else n_pass++;
        n_checks++; if (bus.sel !== 3'(m_sel) || bus.out_data !== 8'(m_data)) $display("FAIL rnd_hold%0d: got sel=%0d data=%h want %0d/%h", n, bus.sel, bus.out_data, m_sel, m_data); else n_pass++;
      end else begin
        m_sel = t; m_data = data;
        n_checks++; if (bus.out_valid !== (8'd1 << t) || bus.sel !== 3'(t) || bus.out_data !== 8'(data))
          $display("FAIL rnd_send%0d: got valid=%h sel=%0d data=%h want %h/%0d/%h", n, bus.out_valid, bus.sel, bus.out_data, 8'd1 << t, t, data);
        else n_pass++;
        d = $urandom_range(0, 5);
        done = 1'b0;
        for (int k = 0; k < int'(TO) && !done; k++) begin
          bus.mode = 1'($urandom); bus.en_mask = 8'($urandom);
          bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
          if (k < int'(d)) bus.out_ready = 8'($urandom) & ~(8'd1 << t);
          else             bus.out_ready = 8'($urandom) |  (8'd1 << t);
          tick();
          bus.in_valid = 1'b0;
          if (k >= int'(d)) begin
            done = 1'b1;
            if (md == 1) m_ptr = (t + 1) % 8;
          end else if (k == int'(TO) - 1) begin
            done = 1'b1;
            if (m_drops < 255) m_drops++;
          end
          if (done) begin
            n_checks++; if (bus.out_valid !== 8'h00 || bus.in_ready !== 1'b1) $display("FAIL rnd_end%0d: got valid=%h rdy=%b want 00/1", n, bus.out_valid, bus.in_ready); else n_pass++;
          end else begin
            n_checks++; if (bus.out_valid !== (8'd1 << t)) $display("FAIL rnd_hold_send%0d: got %h want %h", n, bus.out_valid, 8'd1 << t); else n_pass++;
          end
        end
        n_checks++; if (bus.out_data !== 8'(m_data)) $display("FAIL rnd_data_hold%0d: got %h want %h", n, bus.out_data, m_data); else n_pass++;
      end
      n_checks++; if (bus.drop_cnt !== 8'(m_drops)) $display("FAIL rnd_dropcnt%0d: got %0d want %0d", n, bus.drop_cnt, m_drops); else n_pass++;
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    bus.mode = 1'b0; bus.en_mask = 8'h00; bus.in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.mode = 1'($urandom); bus.in_dest = 3'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.drop_cnt !== 8'd255) $display("FAIL sat_drop: got %0d want 255", bus.drop_cnt); else n_pass++;
    bus.mode = 1'b0; bus.en_mask = 8'hFF; bus.in_dest = 3'd3; bus.in_data = 8'h5A;
    bus.out_ready = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 8'h08) $display("FAIL sat_send: got busy=%b valid=%h want 1/08", bus.busy, bus.out_valid); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 8'h00) $display("FAIL rst_valid: got %h want 00", bus.out_valid); else n_pass++;
    n_checks++; if (bus.drop_cnt !== 8'd0) $display("FAIL rst_drop: got %0d want 0", bus.drop_cnt); else n_pass++;
    n_checks++; if (bus.sel !== 3'd0 || bus.out_data !== 8'h00) $display("FAIL rst_sel_data: got sel=%0d data=%h want 0/00", bus.sel, bus.out_data); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.drop_cnt !== 8'd0) $display("FAIL rst_release: got rdy=%b drop=%0d want 1/0", bus.in_ready, bus.drop_cnt); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_addressed();
    test_disabled_dest();
    test_round_robin();
    test_timeout();
    test_back_to_back();
    test_random();
    test_saturation_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
